// File: rtl/pr_graph_loader.sv
// Graph loader: collects edges into an adjacency matrix, then derives 1/outdeg weights per node via serial restoring divide.
// Optional macro PR_SELF_LOOP_FILTER_EN drops src==dst edges at load time.
module pr_graph_loader #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int IW   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 edge_valid,
  output logic                 edge_ready,
  input  logic [IW-1:0]        edge_src,
  input  logic [IW-1:0]        edge_dst,
  input  logic                 edge_last,
  output logic [N*N-1:0]       adjacency,
  output logic [N*WIDTH-1:0]   weights,
  output logic                 busy,
  output logic                 graph_valid
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int DW = IW + 2;
  localparam logic [IW:0] N_L = (IW + 1)'(N);

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

  state_t             state, state_next;
  logic [IW:0]        outdeg [N];
  logic [WIDTH-1:0]   wt [N];
  logic [IW-1:0]      node;
  logic [SW-1:0]      step;
  logic [IW:0]        rem;
  logic [IW:0]        divisor;
  logic [WIDTH-2:0]   quo;
  logic [DW-1:0]      trial;
  logic               ge;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   wt_new;
  logic               take;
  logic               legal;
  logic               slot_end;
  logic [2*IW-1:0]    adj_idx;

  assign edge_ready  = (state == LOAD) && !clear;
  assign take        = edge_valid && edge_ready;
  assign busy        = (state == COMPUTE);
  assign graph_valid = (state == DONE);
  assign slot_end    = (state == COMPUTE) && (step == SW'(WIDTH));
  assign adj_idx     = (2*IW)'(edge_dst) * (2*IW)'(N) + (2*IW)'(edge_src);

  always_comb begin
    legal = ({1'b0, edge_src} < N_L) && ({1'b0, edge_dst} < N_L);
`ifdef PR_SELF_LOOP_FILTER_EN
    legal = legal && (edge_src != edge_dst);
`endif
  end

  // The dividend 2^WIDTH starts as remainder 1; each step shifts in a zero bit.
  always_comb begin
    trial    = {1'b0, rem, 1'b0};
    ge       = (trial >= {1'b0, divisor});
    quo_next = {quo, ge};
    if (divisor == '0)
      wt_new = '0;
    else if (divisor == (IW + 1)'(1))
      wt_new = '1;
    else
      wt_new = quo_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (take && edge_last) state_next = COMPUTE;
      COMPUTE: if (slot_end && node == IW'(N - 1)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
    if (clear) state_next = LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adjacency <= '0;
      node      <= '0;
      step      <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      for (int i = 0; i < N; i++) begin
        outdeg[i] <= '0;
        wt[i]     <= '0;
      end
    end else if (clear) begin
      adjacency <= '0;
      node      <= '0;
      step      <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      for (int i = 0; i < N; i++) begin
        outdeg[i] <= '0;
        wt[i]     <= '0;
      end
    end else begin
      // Duplicates leave the degree untouched, which bounds outdeg by N.
      if (take && legal && !adjacency[adj_idx]) begin
        adjacency[adj_idx] <= 1'b1;
        outdeg[edge_src]   <= outdeg[edge_src] + 1'b1;
      end
      if (state == COMPUTE) begin
        if (step == '0) begin
          rem     <= (IW + 1)'(1);
          quo     <= '0;
          divisor <= outdeg[node];
          step    <= step + 1'b1;
        end else begin
          rem <= (IW + 1)'(ge ? trial - {1'b0, divisor} : trial);
          quo <= quo_next[WIDTH-2:0];
          if (slot_end) begin
            wt[node] <= wt_new;
            step     <= '0;
            node     <= node + 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
      end
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_wout
    assign weights[n*WIDTH +: WIDTH] = wt[n];
  end

endmodule

// File: tb/tb_pr_graph_loader.sv
// Self-checking bench for pr_graph_loader: fixed vectors, corner sequences, random graphs vs. a set-based model.
module tb_pr_graph_loader;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int IW    = 2;
  localparam int LAT   = N * (WIDTH + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                clear;
  logic                edge_valid;
  logic                edge_ready;
  logic [IW-1:0]       edge_src;
  logic [IW-1:0]       edge_dst;
  logic                edge_last;
  logic [N*N-1:0]      adjacency;
  logic [N*WIDTH-1:0]  weights;
  logic                busy;
  logic                graph_valid;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] q_src[$];
  logic [IW-1:0] q_dst[$];

  typedef struct {
    logic [31:0]        edges;
    int                 ne;
    logic [N*N-1:0]     adj;
    logic [N*WIDTH-1:0] w;
  } vec_t;

  vec_t tbl[5];

  pr_graph_loader #(.N(N), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .edge_valid  (edge_valid),
    .edge_ready  (edge_ready),
    .edge_src    (edge_src),
    .edge_dst    (edge_dst),
    .edge_last   (edge_last),
    .adjacency   (adjacency),
    .weights     (weights),
    .busy        (busy),
    .graph_valid (graph_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: adjacency as a set of (src,dst) pairs, weight from the counted out-degree.
  function automatic void model(output logic [N*N-1:0] ea, output logic [N*WIDTH-1:0] ew);
    bit     adj[N][N];
    int     deg;
    longint w;
    ea = '0;
    ew = '0;
    for (int d = 0; d < N; d++)
      for (int s = 0; s < N; s++) adj[d][s] = 1'b0;
    for (int i = 0; i < q_src.size(); i++) begin
`ifdef PR_SELF_LOOP_FILTER_EN
      if (q_src[i] == q_dst[i]) continue;
`endif
      adj[q_dst[i]][q_src[i]] = 1'b1;
    end
    for (int d = 0; d < N; d++)
      for (int s = 0; s < N; s++) ea[d*N+s] = adj[d][s];
    for (int s = 0; s < N; s++) begin
      deg = 0;
      for (int d = 0; d < N; d++) deg += int'(adj[d][s]);
      if (deg == 0)      w = 0;
      else if (deg == 1) w = (64'd1 << WIDTH) - 1;
      else               w = (64'd1 << WIDTH) / deg;
      ew[s*WIDTH +: WIDTH] = w[WIDTH-1:0];
    end
  endfunction

  task automatic load_queue(input logic [31:0] e, input int ne);
    q_src.delete();
    q_dst.delete();
    for (int i = 0; i < ne; i++) begin
      q_src.push_back(e[4*i+2 +: 2]);
      q_dst.push_back(e[4*i +: 2]);
    end
  endtask

  // Returns right after the posedge that completes the final (edge_last) handshake.
  task automatic send_edges(input int gap_max, input string nm);
    int g;
    for (int i = 0; i < q_src.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        edge_valid = 1'b0;
      end
      @(negedge clk);
      edge_valid = 1'b1;
      edge_src   = q_src[i];
      edge_dst   = q_dst[i];
      edge_last  = (i == q_src.size() - 1);
      #1;
      chk($sformatf("%s.ready%0d", nm, i), edge_ready, 1'b1);
      @(posedge clk);
    end
  endtask

  task automatic finish_graph(input logic [N*N-1:0] ea, input logic [N*WIDTH-1:0] ew, input string nm);
    int                 k;
    bit                 seen;
    logic [N*WIDTH-1:0] part;
    part = '0;
    part[WIDTH-1:0] = ew[WIDTH-1:0];
    #1;
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    chk($sformatf("%s.busy_start", nm), busy, 1'b1);
    chk($sformatf("%s.ready_compute", nm), edge_ready, 1'b0);
    k = 0;
    seen = 0;
    while (k < 200 && !seen) begin
      @(posedge clk);
      k++;
      #1;
      if (k == WIDTH)     chk($sformatf("%s.w_before_slot0", nm), weights, '0);
      if (k == WIDTH + 1) chk($sformatf("%s.w_after_slot0", nm), weights, part);
      if (graph_valid) seen = 1;
    end
    chk($sformatf("%s.latency", nm), k, LAT);
    chk($sformatf("%s.adj", nm), adjacency, ea);
    chk($sformatf("%s.weights", nm), weights, ew);
    chk($sformatf("%s.busy_done", nm), busy, 1'b0);
    chk($sformatf("%s.ready_done", nm), edge_ready, 1'b0);
  endtask

  task automatic do_clear(input string nm);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    chk($sformatf("%s.clr_valid", nm), graph_valid, 1'b0);
    chk($sformatf("%s.clr_adj", nm), adjacency, '0);
    chk($sformatf("%s.clr_w", nm), weights, '0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk($sformatf("%s.clr_ready", nm), edge_ready, 1'b1);
  endtask

  initial begin
    logic [N*N-1:0]     ea;
    logic [N*WIDTH-1:0] ew;
    int                 ne;

    tbl[0] = '{32'hEC87_6321, 8, 16'h3B1C, 64'h8000_FFFF_8000_5555};
    tbl[1] = '{32'h0000_0411, 3, 16'h0012, 64'h0000_0000_FFFF_FFFF};
`ifdef PR_SELF_LOOP_FILTER_EN
    tbl[2] = '{32'h0000_000A, 1, 16'h0000, 64'h0000_0000_0000_0000};
`else
    tbl[2] = '{32'h0000_000A, 1, 16'h0400, 64'h0000_FFFF_0000_0000};
`endif
    tbl[3] = '{32'h0000_4321, 4, 16'h1112, 64'h0000_0000_FFFF_5555};
    tbl[4] = '{32'h0000_9DDD, 4, 16'h00C0, 64'hFFFF_FFFF_0000_0000};

    reset = 1'b1;
    clear = 1'b0;
    edge_valid = 1'b0;
    edge_src = '0;
    edge_dst = '0;
    edge_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.adj", adjacency, '0);
    chk("rst.w", weights, '0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.valid", graph_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.ready", edge_ready, 1'b1);

    for (int k = 0; k < 5; k++) begin
      load_queue(tbl[k].edges, tbl[k].ne);
      send_edges(0, $sformatf("vec%0d", k));
      finish_graph(tbl[k].adj, tbl[k].w, $sformatf("vec%0d", k));
      do_clear($sformatf("vec%0d", k));
    end

    // Asynchronous reset in the middle of COMPUTE, then an identical reload.
    load_queue(tbl[0].edges, tbl[0].ne);
    send_edges(0, "midrst");
    #1;
    edge_valid = 1'b0;
    edge_last  = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("midrst.busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst.adj", adjacency, '0);
    chk("midrst.w", weights, '0);
    chk("midrst.busy", busy, 1'b0);
    chk("midrst.valid", graph_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst.ready", edge_ready, 1'b1);
    send_edges(0, "reload");
    finish_graph(tbl[0].adj, tbl[0].w, "reload");
    do_clear("reload");

    // clear wins over a simultaneous edge offer.
    @(negedge clk);
    clear = 1'b1;
    edge_valid = 1'b1;
    edge_src = 2'd1;
    edge_dst = 2'd3;
    edge_last = 1'b1;
    #1;
    chk("clrwin.ready", edge_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("clrwin.adj", adjacency, '0);
    chk("clrwin.busy", busy, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    edge_valid = 1'b0;
    edge_last = 1'b0;
    #1;
    chk("clrwin.ready_after", edge_ready, 1'b1);

    for (int r = 0; r < 20; r++) begin
      q_src.delete();
      q_dst.delete();
      ne = int'($urandom_range(12, 1));
      for (int i = 0; i < ne; i++) begin
        q_src.push_back(IW'($urandom_range(N - 1, 0)));
        q_dst.push_back(IW'($urandom_range(N - 1, 0)));
      end
      model(ea, ew);
      send_edges(3, $sformatf("rnd%0d", r));
      finish_graph(ea, ew, $sformatf("rnd%0d", r));
      do_clear($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
